// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: sequencer states and PC constants,
// also used by the PC mux and the IF/ID stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_t;

   localparam int unsigned PC_STEP          = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_adder.sv
// Sequential-PC incrementer (pc + PC_STEP, wrapping at 2^ADDR_W);
// also reused by the branch-target path.
module pc_adder
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] i_pc,
   output logic [ADDR_W-1:0] o_pc_plus4
);

   assign o_pc_plus4 = i_pc + ADDR_W'(PC_STEP);

endmodule

// File: rtl/pc_fetch_reg.sv
// PC register and single-outstanding fetch sequencer feeding IF/ID.
//
// state  | meaning
// S_IDLE | just out of reset, no request issued yet
// S_REQ  | request for pc presented to instruction memory
// S_WAIT | request accepted, waiting for the response word
// S_HOLD | fetched word presented to IF/ID until consumed
module pc_fetch_reg
   import fetch_pkg::*;
#(
   parameter int                 ADDR_W   = 32,
   parameter int                 DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] next_pc,
   input  logic              redirect,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              if_ready
);

   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_req_pc;
   logic [ADDR_W-1:0] r_if_pc;
   logic [DATA_W-1:0] r_if_instr;
   logic              r_squash;

   logic [ADDR_W-1:0] w_next_pc_al;
   logic [ADDR_W-1:0] w_pc_plus4;

   // Loaded PCs are always word aligned, whatever the mux presents.
   assign w_next_pc_al = next_pc & ~ADDR_W'(3);

   pc_adder #(.ADDR_W(ADDR_W)) u_pc_adder (
      .i_pc       (r_pc),
      .o_pc_plus4 (w_pc_plus4)
   );

   assign pc             = r_pc;
   assign pc_plus4       = w_pc_plus4;
   assign imem_req_valid = (r_state == S_REQ);
   assign imem_req_addr  = r_pc;
   assign if_valid       = (r_state == S_HOLD);
   assign if_instr       = r_if_instr;
   assign if_pc          = r_if_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_req_pc   <= '0;
         r_if_pc    <= '0;
         r_if_instr <= '0;
         r_squash   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_REQ;
            S_REQ: begin
               if (redirect || imem_req_ready) r_pc <= w_next_pc_al;
               if (imem_req_ready) begin
                  r_req_pc <= r_pc;
                  r_squash <= redirect;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (redirect) r_pc <= w_next_pc_al;
               if (imem_rsp_valid) begin
                  // A stale or redirected word is dropped and fetch restarts at pc.
                  if (r_squash || redirect) begin
                     r_squash <= 1'b0;
                     r_state  <= S_REQ;
                  end else begin
                     r_if_instr <= imem_rsp_data;
                     r_if_pc    <= r_req_pc;
                     r_state    <= S_HOLD;
                  end
               end else if (redirect) begin
                  r_squash <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect) begin
                  r_pc    <= w_next_pc_al;
                  r_state <= S_REQ;
               end else if (if_ready) begin
                  r_state <= S_REQ;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Bench for pc_fetch_reg: directed sequences, a redirect/alignment vector
// table and a randomized run against a fetch-stream reference model.
module tb_pc_fetch_reg;

   localparam logic [31:0] MAGIC = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic        req_ready = 1'b0;
   logic        rsp_valid = 1'b0;
   logic        if_ready = 1'b0;
   logic [31:0] tgt = 32'h0;
   logic [31:0] rsp_data = 32'h0;
   logic [31:0] next_pc, next_pc_w;

   logic [31:0] pc, pc_plus4, req_addr, if_instr, if_pc;
   logic        req_valid, if_valid;
   logic [31:0] pc_w, pc_plus4_w, req_addr_w, if_instr_w, if_pc_w;
   logic        req_valid_w, if_valid_w;

   // External PC mux: target on redirect, otherwise the sequential PC.
   assign next_pc   = redirect ? tgt : pc_plus4;
   assign next_pc_w = redirect ? tgt : pc_plus4_w;

   always #5 clk = ~clk;

   pc_fetch_reg #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect),
      .pc(pc), .pc_plus4(pc_plus4),
      .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
   );

   // Second instance at the top of the address space, run in lockstep.
   pc_fetch_reg #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst), .next_pc(next_pc_w), .redirect(redirect),
      .pc(pc_w), .pc_plus4(pc_plus4_w),
      .imem_req_valid(req_valid_w), .imem_req_addr(req_addr_w), .imem_req_ready(req_ready),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .if_valid(if_valid_w), .if_instr(if_instr_w), .if_pc(if_pc_w), .if_ready(if_ready)
   );

   int tests = 0;
   int fails = 0;

   // memory model state
   bit          pend = 1'b0;
   int          cnt = 0;
   int          lat_lo = 1, lat_hi = 1;
   logic [31:0] maddr = 32'h0;
   logic [31:0] mq[$];
   logic [31:0] wq[$];

   // reference model: next instruction address the stream must deliver
   logic [31:0] exp_pc = 32'h0;
   int          since_rst = 0;

   // per-cycle samples
   logic        s_reqv, s_ifv, s_reqv_w, s_ifv_w, s_hs;
   logic [31:0] s_pc, s_plus4, s_addr, s_ifpc, s_instr;
   logic [31:0] s_pc_w, s_plus4_w, s_addr_w, s_ifpc_w;
   bit          p_ok = 1'b0, p_hs = 1'b0, p_redir = 1'b0, p_hold = 1'b0;
   logic [31:0] p_pc, p_ifpc, p_instr;

   typedef struct {
      logic [31:0] tgt;
      logic [31:0] pc;
      logic [31:0] plus4;
   } vec_t;
   vec_t vt[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   task automatic cyc();
      rsp_valid = pend && (cnt == 0);
      rsp_data  = rsp_valid ? (maddr ^ MAGIC) : 32'hDEAD_BEEF;
      @(negedge clk);
      s_reqv = req_valid;  s_ifv = if_valid;  s_pc = pc;  s_plus4 = pc_plus4;
      s_addr = req_addr;   s_ifpc = if_pc;    s_instr = if_instr;
      s_reqv_w = req_valid_w; s_ifv_w = if_valid_w; s_pc_w = pc_w;
      s_plus4_w = pc_plus4_w; s_addr_w = req_addr_w; s_ifpc_w = if_pc_w;
      s_hs = s_reqv && req_ready && !rst;
      if (!rst) begin
         if (p_ok && !p_hs && !p_redir) chk("pc_stable", s_pc, p_pc);
         if (p_ok && p_hold && !p_redir) begin
            chk("hold_valid", 32'(s_ifv), 32'd1);
            chk("hold_pc", s_ifpc, p_ifpc);
            chk("hold_instr", s_instr, p_instr);
         end
         if (s_reqv) chk("one_outstanding", 32'(pend), 32'd0);
         if (s_reqv && !redirect) chk("req_addr", s_addr, exp_pc);
         if (s_ifv && !redirect) begin
            chk("if_pc", s_ifpc, exp_pc);
            chk("if_instr", s_instr, exp_pc ^ MAGIC);
         end
         if (redirect) exp_pc = tgt & ~32'h3;
         else if (s_ifv && if_ready) exp_pc = exp_pc + 32'd4;
      end
      p_ok = !rst; p_hs = s_hs; p_redir = redirect; p_pc = s_pc;
      p_hold = s_ifv && !if_ready; p_ifpc = s_ifpc; p_instr = s_instr;
      @(posedge clk);
      #1;
      if (rsp_valid) pend = 1'b0;
      else if (pend && cnt > 0) cnt--;
      if (s_hs) begin
         pend  = 1'b1;
         cnt   = int'($urandom_range(lat_hi - 1, lat_lo - 1));
         maddr = s_addr;
         mq.push_back(s_addr);
      end
      if (s_reqv_w && req_ready && !rst) wq.push_back(s_addr_w);
      if (rst) begin
         exp_pc = 32'h0;
         since_rst = 0;
      end else begin
         since_rst++;
      end
   endtask

   task automatic wait_ifv(input string nm, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!s_ifv && n < 20);
      if (!s_ifv) timeout(nm);
   endtask

   initial begin
      int n;
      vt[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
      vt[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
      vt[2] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008};
      vt[3] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};
      vt[4] = '{32'h0000_0FFC, 32'h0000_0FFC, 32'h0000_1000};

      // reset state
      rst = 1'b1; cyc(); cyc();
      chk("rst_pc", s_pc, 32'h0);
      chk("rst_plus4", s_plus4, 32'h4);
      chk("rst_req_valid", 32'(s_reqv), 32'd0);
      chk("rst_if_valid", 32'(s_ifv), 32'd0);
      chk("rst_if_pc", s_ifpc, 32'h0);
      chk("rst_if_instr", s_instr, 32'h0);
      chk("rst_wrap_pc", s_pc_w, 32'hFFFF_FFFC);
      chk("rst_wrap_plus4", s_plus4_w, 32'h0);

      // straight-line fetch, 1-cycle memory
      rst = 1'b0; req_ready = 1'b1; if_ready = 1'b1;
      wait_ifv("first_ifv", n);
      chk("first_ifv_latency", 32'(n - 1), 32'd3);
      chk("first_if_pc", s_ifpc, 32'h0);
      chk("first_if_instr", s_instr, MAGIC);
      chk("wrap_first_if_pc", s_ifpc_w, 32'hFFFF_FFFC);

      // stall while holding the 0x4 word
      if_ready = 1'b0;
      wait_ifv("second_ifv", n);
      chk("second_if_pc", s_ifpc, 32'h4);
      chk("second_if_instr", s_instr, 32'hA5A5_0004);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("stall_valid", 32'(s_ifv), 32'd1);
         chk("stall_if_pc", s_ifpc, 32'h4);
         chk("stall_req_valid", 32'(s_reqv), 32'd0);
         chk("stall_pc", s_pc, 32'h8);
      end
      if_ready = 1'b1;
      cyc();
      if (wq.size() >= 2) chk("wrap_second_req", wq[1], 32'h0);
      else timeout("wrap_second_req");

      // redirect to 0x100 while waiting on the 0x8 request
      cyc();
      chk("req8_valid", 32'(s_reqv), 32'd1);
      chk("req8_addr", s_addr, 32'h8);
      redirect = 1'b1; tgt = 32'h100;
      cyc();
      redirect = 1'b0;
      wait_ifv("redir_wait_ifv", n);
      chk("redir_wait_if_pc", s_ifpc, 32'h100);
      if (mq.size() >= 4) begin
         chk("mq0", mq[0], 32'h0);
         chk("mq1", mq[1], 32'h4);
         chk("mq2", mq[2], 32'h8);
         chk("mq3", mq[3], 32'h100);
      end else timeout("mq_size");

      // redirect to 0x200 in the same cycle as the handshake for 0x104
      redirect = 1'b1; tgt = 32'h200;
      cyc();
      redirect = 1'b0;
      chk("hs_redir_req_valid", 32'(s_reqv), 32'd1);
      chk("hs_redir_req_addr", s_addr, 32'h104);
      wait_ifv("hs_redir_ifv", n);
      chk("hs_redir_if_pc", s_ifpc, 32'h200);
      chk("hs_redir_last_req", mq[mq.size() - 1], 32'h200);

      // redirect alignment / pc_plus4 table while parked in S_REQ
      req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         redirect = 1'b1; tgt = vt[i].tgt;
         cyc();
         redirect = 1'b0;
         cyc();
         chk("vec_pc", s_pc, vt[i].pc);
         chk("vec_plus4", s_plus4, vt[i].plus4);
         chk("vec_req_addr", s_addr, vt[i].pc);
         chk("vec_req_valid", 32'(s_reqv), 32'd1);
         chk("vec_wrap_pc", s_pc_w, vt[i].pc);
      end
      req_ready = 1'b1;

      // reset during S_WAIT; the late response must be ignored
      lat_lo = 2; lat_hi = 2;
      n = 0;
      do begin cyc(); n++; end while (!s_hs && n < 20);
      if (!s_hs) timeout("rst_mid_hs");
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      chk("rstw_if_valid", 32'(s_ifv), 32'd0);
      chk("rstw_req_valid", 32'(s_reqv), 32'd0);
      chk("rstw_pc", s_pc, 32'h0);
      cyc();
      chk("rstw_reissue_valid", 32'(s_reqv), 32'd1);
      chk("rstw_reissue_addr", s_addr, 32'h0);
      wait_ifv("rstw_ifv", n);
      chk("rstw_if_pc", s_ifpc, 32'h0);
      chk("rstw_if_instr", s_instr, MAGIC);

      // randomized run against the stream model
      lat_lo = 1; lat_hi = 3;
      for (int i = 0; i < 1500; i++) begin
         req_ready = ($urandom % 4) != 0;
         if_ready  = ($urandom % 3) != 0;
         redirect  = (($urandom % 10) == 0) && (since_rst >= 1);
         tgt       = $urandom;
         cyc();
      end
      redirect = 1'b0; req_ready = 1'b1; if_ready = 1'b1;
      for (int i = 0; i < 10; i++) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
